// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared types, constants and helpers for the serial transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

    localparam int SER_WIDTH     = 4;
    localparam int SER_MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } tx_state_t;

    // Callers zero-extend narrower words; padding does not change even parity.
    function automatic logic even_parity(input logic [SER_MAX_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_tx_hold.sv
// ============================================================================
// Module      : serial_tx_hold
// Description : One-entry valid/ready holding register feeding the shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx_hold #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;
    logic             w_accept;

    // Ready depends only on stored state, never on din_valid.
    assign din_ready = !r_full && !reset;
    assign w_accept  = din_valid && din_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_full <= 1'b1;
            r_data <= din;
        end else if (pop) begin
            r_full <= 1'b0;
        end
    end

    assign dout = r_data;
    assign full = r_full;

endmodule

`default_nettype wire

// File: rtl/serial_tx.sv
// ============================================================================
// Module      : serial_tx
// Description : Parallel-in/serial-out transmitter with valid/ready input.
//               Define SERIAL_TX_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_tx
    import serial_pkg::*;
#(
    parameter int   WIDTH      = SER_WIDTH,
    parameter int   MSB_FIRST  = 1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             done
);

    localparam int             CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  C_ONE  = CW'(1);

    tx_state_t        r_state;
    tx_state_t        w_state_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH-1:0] w_hold_dout;
    logic [CW-1:0]    r_bit_cnt;
    logic             w_hold_full;
    logic             w_load;
    logic             w_last;
    logic             w_cur_bit;

    serial_tx_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .pop       (w_load),
        .dout      (w_hold_dout),
        .full      (w_hold_full)
    );

    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign w_cur_bit    = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_cur_bit    = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    assign w_last = (r_bit_cnt == C_LAST);
    assign busy   = (r_state != ST_IDLE) || w_hold_full;

`ifdef SERIAL_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= even_parity(SER_MAX_WIDTH'(w_hold_dout));
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        serial_valid = 1'b0;
        serial_out   = IDLE_LEVEL;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                serial_valid = 1'b1;
                serial_out   = w_cur_bit;
                if (w_last) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_next = ST_PARITY;
`else
                    done = 1'b1;
                    // Reload straight from hold so consecutive frames have no gap.
                    if (w_hold_full) begin
                        w_load       = 1'b1;
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
`endif
                end
            end
            ST_PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
                serial_valid = 1'b1;
                serial_out   = r_parity;
                done         = 1'b1;
                if (w_hold_full) begin
                    w_load       = 1'b1;
                    w_state_next = ST_SHIFT;
                end else begin
                    w_state_next = ST_IDLE;
                end
`else
                w_state_next = ST_IDLE;
`endif
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_shift   <= w_hold_dout;
                r_bit_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= r_bit_cnt + C_ONE;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_tx.sv
// ============================================================================
// Module      : tb_serial_tx
// Description : Scoreboard bench for serial_tx (MSB-first and LSB-first DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR   = 1'b1;
    localparam int FRAME = 5;
`else
    localparam bit PAR   = 1'b0;
    localparam int FRAME = 4;
`endif

    typedef struct {
        logic b;
        logic d;
        int   cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [3:0] din_m, din_l;
    logic       din_valid_m, din_valid_l;
    logic       din_ready_m, din_ready_l;
    logic       serial_out_m, serial_out_l;
    logic       serial_valid_m, serial_valid_l;
    logic       busy_m, busy_l;
    logic       done_m, done_l;

    exp_t       q_m[$];
    exp_t       q_l[$];
    exp_t       em, el;
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         run_m = 0, last_run_m = 0;
    int         run_l = 0;
    logic [3:0] ds_q;

    serial_tx #(.WIDTH(4), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) dut_m (
        .clk          (clk),
        .reset        (reset),
        .din          (din_m),
        .din_valid    (din_valid_m),
        .din_ready    (din_ready_m),
        .serial_out   (serial_out_m),
        .serial_valid (serial_valid_m),
        .busy         (busy_m),
        .done         (done_m)
    );

    serial_tx #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk          (clk),
        .reset        (reset),
        .din          (din_l),
        .din_valid    (din_valid_l),
        .din_ready    (din_ready_l),
        .serial_out   (serial_out_l),
        .serial_valid (serial_valid_l),
        .busy         (busy_l),
        .done         (done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream 4-bit serial-in shift register fed by the MSB-first DUT.
    always @(posedge clk) begin
        if (reset) ds_q <= 4'b0000;
        else if (serial_valid_m) ds_q <= {ds_q[2:0], serial_out_m};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: unexpected condition (cycle %0d)", name, cyc);
    endtask

    always @(negedge clk) begin
        if (serial_valid_m) begin
            run_m++;
            if (q_m.size() == 0) fail_now("m_unexpected_bit");
            else begin
                em = q_m.pop_front();
                check("m_bit", serial_out_m, em.b);
                check("m_done", done_m, em.d);
                if (em.cyc >= 0) check("m_latency", cyc, em.cyc);
            end
        end else begin
            if (run_m != 0) last_run_m = run_m;
            run_m = 0;
            if (done_m) fail_now("m_done_while_idle");
            if (serial_out_m !== 1'b0) fail_now("m_idle_level");
        end
    end

    always @(negedge clk) begin
        if (serial_valid_l) begin
            run_l++;
            if (q_l.size() == 0) fail_now("l_unexpected_bit");
            else begin
                el = q_l.pop_front();
                check("l_bit", serial_out_l, el.b);
                check("l_done", done_l, el.d);
                if (el.cyc >= 0) check("l_latency", cyc, el.cyc);
            end
        end else begin
            run_l = 0;
            if (done_l) fail_now("l_done_while_idle");
            if (serial_out_l !== 1'b0) fail_now("l_idle_level");
        end
    end

    // Offer a word (valid stays high afterwards) and queue its expected bits once accepted.
    task automatic send(input bit sel, input logic [3:0] w, input bit chk_lat);
        bit   ok;
        exp_t e;
        if (sel) begin din_l = w; din_valid_l = 1'b1; end
        else     begin din_m = w; din_valid_m = 1'b1; end
        ok = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (sel ? din_ready_l : din_ready_m) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            fail_now("send_timeout");
            return;
        end
        for (int i = 0; i < 4; i++) begin
            e.b   = sel ? w[i] : w[3-i];
            e.d   = (i == 3) && !PAR;
            e.cyc = (chk_lat && i == 0) ? cyc + 2 : -1;
            if (sel) q_l.push_back(e); else q_m.push_back(e);
        end
        if (PAR) begin
            e.b = ^w; e.d = 1'b1; e.cyc = -1;
            if (sel) q_l.push_back(e); else q_m.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (sel ? (q_l.size() == 0 && !busy_l) : (q_m.size() == 0 && !busy_m)) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        @(negedge clk);
    endtask

    initial begin
        int extra;
        reset = 1'b1;
        din_m = 4'h0; din_l = 4'h0;
        din_valid_m = 1'b0; din_valid_l = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_din_ready_low", din_ready_m, 1'b0);
        check("rst_serial_valid", serial_valid_m, 1'b0);
        check("rst_serial_out", serial_out_m, 1'b0);
        check("rst_busy", busy_m, 1'b0);
        check("rst_done", done_m, 1'b0);
        reset = 1'b0;
        #1;
        check("din_ready_after_reset", din_ready_m, 1'b1);
        @(negedge clk);

        // Single word, MSB first, with latency check
        send(1'b0, 4'b1011, 1'b1);
        din_valid_m = 1'b0;
        drain(1'b0);
        check("single_run_len", last_run_m, FRAME);
        check("downstream_q", ds_q, PAR ? 4'b0111 : 4'b1011);

        // Back-to-back: no gap between frames
        send(1'b0, 4'b1011, 1'b1);
        send(1'b0, 4'b0110, 1'b0);
        check("b2b_din_ready_low", din_ready_m, 1'b0);
        din_valid_m = 1'b0;
        drain(1'b0);
        check("b2b_run_len", last_run_m, 2 * FRAME);

        // Backpressure: three words with valid held high
        send(1'b0, 4'b0011, 1'b1);
        send(1'b0, 4'b1001, 1'b0);
        send(1'b0, 4'b0101, 1'b0);
        din_valid_m = 1'b0;
        drain(1'b0);
        check("bp_run_len", last_run_m, 3 * FRAME);

        // Reset after two bits of 4'b1100
        send(1'b0, 4'b1100, 1'b1);
        din_valid_m = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q_m.delete();
        #1;
        check("midrst_serial_valid", serial_valid_m, 1'b0);
        check("midrst_serial_out", serial_out_m, 1'b0);
        check("midrst_busy", busy_m, 1'b0);
        check("midrst_din_ready", din_ready_m, 1'b1);
        extra = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (serial_valid_m) extra++;
        end
        check("midrst_no_more_bits", extra, 0);

        // LSB first
        send(1'b1, 4'b1011, 1'b1);
        din_valid_l = 1'b0;
        drain(1'b1);

        check("final_busy_m", busy_m, 1'b0);
        check("final_busy_l", busy_l, 1'b0);
        check("final_queue_m", q_m.size(), 0);
        check("final_queue_l", q_l.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-in/serial-out transmitter. Sits directly upstream of the team's 4-bit serial-in shift register and drives its serial_in input.
- Accepts words over a valid/ready handshake and stores them in a one-entry holding register.
- Shifts each word out one bit per clock, with a qualifying valid strobe.
- Back-to-back words stream with no idle gap.

Parameters:
- WIDTH, 4, data word width in bits (matches the downstream 4-bit shift register); legal range 2..32.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.
- IDLE_LEVEL, 0, value driven on serial_out whenever serial_valid is low.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-high.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din holds a word.
- din_ready  out  1  holding register empty; a word is accepted on an edge where din_valid && din_ready.
- serial_out  out  1  current serial bit.
- serial_valid  out  1  serial_out carries a frame bit this cycle.
- busy  out  1  shifter active or holding register full.
- done  out  1  high during the cycle the last bit of a frame is presented.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on rising clk.
- Reset values: hold_full=0, state=IDLE, bit_cnt=0, serial_out=IDLE_LEVEL, serial_valid=0, busy=0, done=0. din_ready=0 while reset is high.
- din_ready = !hold_full && !reset. It is purely registered-state driven, with no combinational path from din_valid.
- Accept on edge k: hold <= din, hold_full <= 1. din must not be sampled at any other time.
- States:
  - IDLE: serial_valid=0. If hold_full, the next edge loads the shifter from hold, clears hold_full, sets bit_cnt=0 and goes to SHIFT.
  - SHIFT: serial_out = the current bit (MSB or LSB first per MSB_FIRST), serial_valid=1. Each edge advances bit_cnt.
  - End of data (bit_cnt == WIDTH-1): done=1 this cycle. Next state:
    - PARITY if enabled,
    - otherwise SHIFT with a fresh load if hold_full (zero gap),
    - otherwise IDLE.
- Latency: a word accepted on edge k has its first bit valid in the cycle after edge k+1, so it is presented 2 cycles after acceptance when the shifter is idle.
- Throughput: one word per WIDTH cycles sustained. din_ready reasserts the cycle after hold is transferred to the shifter.
- Simultaneous events:
  - A load from hold and a new acceptance cannot coincide, because din_ready is low while hold_full.
  - A new acceptance during SHIFT is allowed and has no effect on the current frame.
- busy = (state != IDLE) || hold_full.
- bit_cnt width is $clog2(WIDTH+1). The counter wraps to 0 on every frame load and never overflows.
- Reset mid-frame: the partial frame and any held word are discarded. Outputs return to reset values on the next edge.
- din_valid may drop without acceptance; no state changes.

Optional Feature:
- SERIAL_TX_PARITY_EN defined: after the last data bit, one extra PARITY state drives the even-parity bit (XOR of all data bits) with serial_valid=1.
  - done moves to the parity cycle.
  - A frame is WIDTH+1 cycles; back-to-back streaming continues from PARITY.
- Undefined: no PARITY state exists, frames are WIDTH cycles, and done is on the last data bit.

Decomposition:
- Shared package serial_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY),
  - a function to compute even parity,
  - the default width constant SER_WIDTH=4.
- One natural sub-module: serial_tx_hold, the one-entry valid/ready holding register (din, din_valid, din_ready, pop, dout, full). The shifter/FSM stays in the top.

Test Plan:
1. Single word: WIDTH=4, MSB_FIRST=1, din=4'b1011 accepted. Required:
   - serial_valid high for exactly 4 cycles with serial_out=1,0,1,1, starting 2 cycles after acceptance.
   - done on the 4th cycle.
   - The downstream shift register shows q=4'b1011.
2. Back-to-back: 4'b1011 then 4'b0110 offered continuously. Required:
   - 8 consecutive serial_valid cycles, bits 1,0,1,1,0,1,1,0, with no gap.
   - din_ready low from the second acceptance until the second word loads.
3. Backpressure: din_valid held high with three words queued. Required:
   - Each word is accepted only when din_ready=1.
   - No word is lost or duplicated; output order matches input order.
4. Reset mid-frame: reset asserted for 1 cycle after 2 bits of 4'b1100. Required:
   - Next cycle: serial_valid=0, serial_out=IDLE_LEVEL, busy=0, din_ready=1.
   - No further bits of that word are emitted.
5. LSB-first: MSB_FIRST=0, din=4'b1011. Required: serial_out=1,1,0,1.
6. Parity (SERIAL_TX_PARITY_EN defined): din=4'b1011. Required:
   - 5 valid cycles, bits 1,0,1,1,1.
   - done only on the 5th cycle.
